// File: rtl/seq_det_prog_if.sv
// Bus bundle for the programmable serial sequence detector: configuration,
// stream input and match/status outputs.
interface seq_det_prog_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               y;
    logic               count_clr;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, y, count_clr,
        input  z, match_count, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, y, count_clr,
        output z, match_count, cfg_err
    );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with runtime pattern/length/overlap,
// registered one-cycle match pulse and saturating match counter.
module seq_det_prog #(
    parameter int                 MAX_LEN = 16,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(16'b0000000000011010),
    parameter int                 DEF_LEN = 7
) (
    input logic           clk,
    input logic           rst,
    seq_det_prog_if.slave bus
);
    localparam int               LW      = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0]    LEN_MAX = LW'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    // The oldest history bit never reaches a compare, so only MAX_LEN-1 are kept.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill;
    logic [LW-1:0]      len;
    logic               overlap;
    logic               z;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_legal;
    logic               accept;
    logic               enough;
    logic               match;

    always_comb begin
        cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
        accept    = bus.in_valid && !(bus.cfg_load && cfg_legal);
        nxt       = {hist, bus.y};
        len_mask  = ~({MAX_LEN{1'b1}} << len);
        enough    = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
        match     = accept && enough && (((nxt ^ pat) & len_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            pat         <= DEF_PAT;
            len         <= LW'(DEF_LEN);
            overlap     <= 1'b1;
            z           <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            z <= match;

            if (bus.cfg_load) begin
                if (cfg_legal) begin
                    pat     <= bus.cfg_pattern;
                    len     <= bus.cfg_len;
                    overlap <= bus.cfg_overlap;
                    hist    <= '0;
                    fill    <= '0;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            // accept is never true alongside a legal load, so these writes never collide.
            if (accept) begin
                hist <= nxt[MAX_LEN-2:0];
                if (match && !overlap)
                    fill <= '0;
                else if (fill != LEN_MAX)
                    fill <= fill + LW'(1);
            end

            if (bus.count_clr)
                match_count <= '0;
            else if (match && (match_count != CNT_SAT))
                match_count <= match_count + CNT_W'(1);
        end
    end

    assign bus.z           = z;
    assign bus.match_count = match_count;
    assign bus.cfg_err     = cfg_err;
endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: vector table, corner-case sequences,
// saturation on a narrow-counter instance and randomized traffic vs a queue model.
module tb_seq_det_prog;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    seq_det_prog_if #(.MAX_LEN(16), .CNT_W(8)) b ();
    seq_det_prog_if #(.MAX_LEN(16), .CNT_W(4)) b4 ();

    seq_det_prog #(.MAX_LEN(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
    seq_det_prog #(.MAX_LEN(16), .CNT_W(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the bits received since the last restart, newest at the back.
    bit          m_bits[$];
    logic [15:0] m_pat;
    int          m_len;
    bit          m_ov;
    int          m_cnt;
    bit          m_z;
    bit          m_err;

    task automatic model_step(input bit r, input bit ld, input logic [15:0] p, input int l,
                              input bit ov, input bit v, input bit yy, input bit clr);
        bit legal;
        bit hit;
        if (r) begin
            m_bits.delete();
            m_pat = 16'b0000000000011010;
            m_len = 7;
            m_ov  = 1'b1;
            m_z   = 1'b0;
            m_cnt = 0;
            m_err = 1'b0;
            return;
        end
        legal = ld && (l >= 1) && (l <= 16);
        hit = 1'b0;
        if (ld && !legal) m_err = 1'b1;
        if (legal) begin
            m_pat = p;
            m_len = l;
            m_ov  = ov;
            m_bits.delete();
            m_err = 1'b0;
        end else if (v) begin
            m_bits.push_back(yy);
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size()-1-i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ov) m_bits.delete();
        end
        m_z = hit;
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < 255) m_cnt++;
    endtask

    task automatic cycle(input bit r, input bit ld, input logic [15:0] p, input logic [4:0] l,
                         input bit ov, input bit v, input bit yy, input bit clr);
        rst           = r;
        b.cfg_load    = ld;
        b.cfg_pattern = p;
        b.cfg_len     = l;
        b.cfg_overlap = ov;
        b.in_valid    = v;
        b.y           = yy;
        b.count_clr   = clr;
        @(posedge clk);
        model_step(r, ld, p, int'(l), ov, v, yy, clr);
        #1;
        chk("model_z", 32'(b.z), 32'(m_z));
        chk("model_count", 32'(b.match_count), 32'(m_cnt));
        chk("model_cfg_err", 32'(b.cfg_err), 32'(m_err));
    endtask

    task automatic bit_in(input bit yy);
        cycle(0, 0, 16'h0, 5'd0, 0, 1, yy, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 16'h0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic cycle4(input bit r, input bit ld, input bit v, input bit yy, input bit clr);
        rst4           = r;
        b4.cfg_load    = ld;
        b4.cfg_pattern = 16'h0001;
        b4.cfg_len     = 5'd1;
        b4.cfg_overlap = 1'b1;
        b4.in_valid    = v;
        b4.y           = yy;
        b4.count_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          r;
        bit          ld;
        logic [15:0] p;
        logic [4:0]  l;
        bit          ov;
        bit          v;
        bit          yy;
        bit          clr;
        bit          ez;
        int          ecnt;
        bit          eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit ld, logic [15:0] p, logic [4:0] l, bit ov,
                                bit v, bit yy, bit clr, bit ez, int ecnt, bit eerr);
        vec_t t;
        t.r = r; t.ld = ld; t.p = p; t.l = l; t.ov = ov;
        t.v = v; t.yy = yy; t.clr = clr; t.ez = ez; t.ecnt = ecnt; t.eerr = eerr;
        vecs.push_back(t);
    endfunction

    logic [6:0] sa = 7'b0011010;
    logic [6:0] sb = 7'b0011011;
    logic [4:0] s5 = 5'b10101;
    logic [5:0] s6 = 6'b001101;

    initial begin
        b.cfg_load = 0; b.cfg_pattern = '0; b.cfg_len = '0; b.cfg_overlap = 0;
        b.in_valid = 0; b.y = 0; b.count_clr = 0;
        b4.cfg_load = 0; b4.cfg_pattern = '0; b4.cfg_len = '0; b4.cfg_overlap = 0;
        b4.in_valid = 0; b4.y = 0; b4.count_clr = 0;

        // ---- vector table ----
        add(1, 0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 16'h0, 5'd0, 0, 1, sa[6-i], 0, i == 6, (i == 6) ? 1 : 0, 0);
        add(0, 0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 16'h0, 5'd0, 0, 1, sb[6-i], 0, 0, 1, 0);
        add(0, 1, 16'h1234, 5'd0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 16'h0005, 5'd17, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) add(0, 0, 16'h0, 5'd0, 0, 1, sa[6-i], 0, i == 6, (i == 6) ? 2 : 1, 1);
        add(0, 1, 16'h0005, 5'd3, 1, 0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 16'h0, 5'd0, 0, 1, s5[4-i], 0, (i == 2) || (i == 4), (i < 2) ? 2 : (i < 4) ? 3 : 4, 0);
        add(0, 1, 16'h0005, 5'd3, 0, 0, 0, 0, 0, 4, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 16'h0, 5'd0, 0, 1, s5[4-i], 0, i == 2, (i < 2) ? 4 : 5, 0);
        add(0, 0, 16'h0, 5'd0, 0, 0, 0, 1, 0, 0, 0);

        foreach (vecs[k]) begin
            cycle(vecs[k].r, vecs[k].ld, vecs[k].p, vecs[k].l, vecs[k].ov, vecs[k].v, vecs[k].yy, vecs[k].clr);
            chk($sformatf("tbl%0d_z", k), 32'(b.z), 32'(vecs[k].ez));
            chk($sformatf("tbl%0d_count", k), 32'(b.match_count), 32'(vecs[k].ecnt));
            chk($sformatf("tbl%0d_cfg_err", k), 32'(b.cfg_err), 32'(vecs[k].eerr));
        end

        // ---- gaps between valid bits ----
        cycle(1, 0, 16'h0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            bit_in(sa[6-i]);
            chk("gap_bit_z", 32'(b.z), 32'(i == 6));
            idle();
            chk("gap_idle_z", 32'(b.z), 32'd0);
        end
        chk("gap_count", 32'(b.match_count), 32'd1);

        // ---- reset mid-stream ----
        cycle(1, 0, 16'h0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) bit_in(sa[6-i]);
        cycle(1, 0, 16'h0, 5'd0, 0, 0, 0, 0);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("midrst_z", 32'(b.z), 32'd0);
        chk("midrst_count", 32'(b.match_count), 32'd0);

        // ---- legal load mid-stream, bit in the load cycle discarded ----
        for (int i = 0; i < 5; i++) bit_in(sa[6-i]);
        cycle(0, 1, 16'hFFFB, 5'd4, 1, 1, 1, 0);
        bit_in(1); bit_in(0); bit_in(1);
        chk("midload_nomatch", 32'(b.z), 32'd0);
        bit_in(1);
        chk("midload_z", 32'(b.z), 32'd1);
        chk("midload_count", 32'(b.match_count), 32'd1);

        // ---- illegal load with a valid bit processed under the old config ----
        cycle(1, 0, 16'h0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) bit_in(s6[5-i]);
        cycle(0, 1, 16'h0001, 5'd0, 0, 1, 0, 0);
        chk("illegal_valid_z", 32'(b.z), 32'd1);
        chk("illegal_valid_err", 32'(b.cfg_err), 32'd1);

        // ---- count_clr coincident with a match ----
        for (int i = 0; i < 6; i++) bit_in(sa[6-i]);
        cycle(0, 0, 16'h0, 5'd0, 0, 1, 0, 1);
        chk("clr_match_z", 32'(b.z), 32'd1);
        chk("clr_match_count", 32'(b.match_count), 32'd0);

        // ---- saturation on the 4-bit counter instance, len=1 ----
        cycle4(1, 0, 0, 0, 0);
        chk("sat_reset_count", 32'(b4.match_count), 32'd0);
        cycle4(0, 1, 0, 0, 0);
        chk("sat_load_err", 32'(b4.cfg_err), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle4(0, 0, 1, 1, 0);
            chk("sat_z", 32'(b4.z), 32'd1);
            chk("sat_count", 32'(b4.match_count), 32'((i + 1 < 15) ? i + 1 : 15));
        end
        cycle4(0, 0, 1, 1, 1);
        chk("sat_clr_z", 32'(b4.z), 32'd1);
        chk("sat_clr_count", 32'(b4.match_count), 32'd0);
        cycle4(0, 0, 1, 1, 0);
        chk("sat_after_clr", 32'(b4.match_count), 32'd1);
        cycle4(0, 0, 1, 0, 0);
        chk("sat_zero_bit_z", 32'(b4.z), 32'd0);

        // ---- randomized traffic against the model ----
        cycle(1, 0, 16'h0, 5'd0, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            bit          r, ld, ov, v, yy, clr;
            logic [15:0] p;
            logic [4:0]  l;
            r   = ($urandom_range(0, 299) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            p   = 16'($urandom);
            l   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
            ov  = 1'($urandom);
            v   = ($urandom_range(0, 3) != 0);
            yy  = 1'($urandom);
            clr = ($urandom_range(0, 127) == 0);
            cycle(r, ld, p, l, ov, v, yy, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
